// File: rtl/serial_magnitude_comparator_if.sv
// Operand/result handshake bundle for serial_magnitude_comparator.
// The master drives operands and accepts results; the slave is the comparator.
interface serial_magnitude_comparator_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic             Lt;
    logic             Gt;
    logic             Eq;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, Lt, Gt, Eq
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, Lt, Gt, Eq
    );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first unsigned magnitude comparator with valid/ready on both sides.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN: leave SCAN on the first differing bit.
module serial_magnitude_comparator #(
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    serial_magnitude_comparator_if.slave  bus
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               lt_q, lt_d;
    logic               gt_q, gt_d;
    logic               eq_q, eq_d;

    logic               a_bit;
    logic               b_bit;
    logic               decided;

    assign a_bit   = a_q[idx_q];
    assign b_bit   = b_q[idx_q];
    assign decided = lt_q | gt_q;

    // NOTE: every comb output gets its hold value first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    idx_d   = IDX_W'(WIDTH - 1);
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // Once Lt or Gt is set, lower bits can no longer change the verdict.
                if (!decided && a_bit && !b_bit) gt_d = 1'b1;
                if (!decided && !a_bit && b_bit) lt_d = 1'b1;
                if (idx_q == '0) begin
                    if (!decided && (a_bit == b_bit)) eq_d = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                if (!decided && (a_bit != b_bit)) state_d = DONE;
`else
                // Constant-time scan: always run down to bit 0.
`endif
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.Lt        = lt_q;
    assign bus.Gt        = gt_q;
    assign bus.Eq        = eq_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed self-checking bench for serial_magnitude_comparator (WIDTH=8).
// Expected latency follows SERIAL_CMP_EARLY_EXIT_EN when the bench is built with it.
module tb_serial_magnitude_comparator;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;
    int   cyc_cnt;
    int   t0;

    serial_magnitude_comparator_if #(.WIDTH(WIDTH)) bus ();

    serial_magnitude_comparator #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        bit               lt;
        bit               gt;
        bit               eq;
        int               p;   // most significant differing bit, -1 when equal
    } vec_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int exp_lat(input int p);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        return (p < 0) ? WIDTH : WIDTH - p;
`else
        return WIDTH;
`endif
    endfunction

    // Present one operand pair on a falling edge; returns just after the accept edge.
    task automatic start(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        @(posedge clk);
        #1;
        t0           = cyc_cnt;
        bus.in_valid = 1'b0;
        bus.A        = ~a;
        bus.B        = ~b;
    endtask

    task automatic await_result(input string tag, input bit elt, input bit egt,
                                input bit eeq, input int elat);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 4 * WIDTH) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.out_valid !== 1'b1) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        check({tag, "_latency"},  32'(cyc_cnt - t0), 32'(elat));
        check({tag, "_lt"},       32'(bus.Lt), 32'(elt));
        check({tag, "_gt"},       32'(bus.Gt), 32'(egt));
        check({tag, "_eq"},       32'(bus.Eq), 32'(eeq));
        check({tag, "_busy"},     32'(bus.in_ready), 32'd0);
    endtask

    // With out_ready high, out_valid must drop after exactly one cycle.
    task automatic handoff(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_idle"},       32'(bus.in_ready), 32'd1);
    endtask

    vec_t vecs[7];

    initial begin
        passed        = 0;
        total         = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.out_ready = 1'b1;

        vecs[0] = '{8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, -1};
        vecs[1] = '{8'h80, 8'h7F, 1'b0, 1'b1, 1'b0,  7};
        vecs[2] = '{8'h12, 8'h13, 1'b1, 1'b0, 1'b0,  0};
        vecs[3] = '{8'h48, 8'h37, 1'b0, 1'b1, 1'b0,  6};
        vecs[4] = '{8'h02, 8'h01, 1'b0, 1'b1, 1'b0,  1};
        vecs[5] = '{8'h00, 8'hFF, 1'b1, 1'b0, 1'b0,  7};
        vecs[6] = '{8'hFE, 8'hFF, 1'b1, 1'b0, 1'b0,  0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_lt",        32'(bus.Lt),        32'd0);
        check("rst_gt",        32'(bus.Gt),        32'd0);
        check("rst_eq",        32'(bus.Eq),        32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("v%0d", i);
            start(tag, vecs[i].a, vecs[i].b);
            await_result(tag, vecs[i].lt, vecs[i].gt, vecs[i].eq, exp_lat(vecs[i].p));
            handoff(tag);
        end

        // Result must hold while the consumer stalls.
        bus.out_ready = 1'b0;
        start("hold", 8'h0F, 8'h1F);
        await_result("hold", 1'b1, 1'b0, 1'b0, exp_lat(4));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_valid_%0d", k), 32'(bus.out_valid), 32'd1);
            check($sformatf("hold_lt_%0d", k),    32'(bus.Lt),        32'd1);
            check($sformatf("hold_ready_%0d", k), 32'(bus.in_ready),  32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        handoff("hold");
        check("hold_lt_kept", 32'(bus.Lt), 32'd1);

        // A second pair offered mid-scan must be ignored.
        start("busy", 8'h01, 8'h02);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.A        = 8'hFF;
        bus.B        = 8'h00;
        @(negedge clk);
        bus.in_valid = 1'b0;
        await_result("busy", 1'b1, 1'b0, 1'b0, exp_lat(1));
        handoff("busy");
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("busy_no_accept_%0d", k), 32'(bus.in_ready), 32'd1);
        end

        // Reset in the middle of a scan aborts it.
        start("abort", 8'h55, 8'h55);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready",  32'(bus.in_ready),  32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_lt",        32'(bus.Lt),        32'd0);
        check("abort_gt",        32'(bus.Gt),        32'd0);
        check("abort_eq",        32'(bus.Eq),        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start("post", 8'hC3, 8'hC4);
        await_result("post", 1'b1, 1'b0, 1'b0, exp_lat(2));
        handoff("post");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
